// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared widths, state encoding, opcode/condition/shift codes for dp_controller
package dp_ctrl_pkg;
   localparam int RF_AW = 4;
   localparam int OP_W  = 4;
   localparam logic [2:0] ST_WAIT    = 3'd0;
   localparam logic [2:0] ST_LOAD_AB = 3'd1;
   localparam logic [2:0] ST_LOAD_S  = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_WB      = 3'd4;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_RSC = 4'b0111;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_TEQ = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_MVN = 4'b1111;
   localparam logic [3:0] CC_EQ = 4'h0;
   localparam logic [3:0] CC_NE = 4'h1;
   localparam logic [3:0] CC_CS = 4'h2;
   localparam logic [3:0] CC_CC = 4'h3;
   localparam logic [3:0] CC_MI = 4'h4;
   localparam logic [3:0] CC_PL = 4'h5;
   localparam logic [3:0] CC_VS = 4'h6;
   localparam logic [3:0] CC_VC = 4'h7;
   localparam logic [3:0] CC_HI = 4'h8;
   localparam logic [3:0] CC_LS = 4'h9;
   localparam logic [3:0] CC_GE = 4'hA;
   localparam logic [3:0] CC_LT = 4'hB;
   localparam logic [3:0] CC_GT = 4'hC;
   localparam logic [3:0] CC_LE = 4'hD;
   localparam logic [3:0] CC_AL = 4'hE;
   localparam logic [3:0] CC_NV = 4'hF;
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;
endpackage

// File: rtl/dp_controller_if.sv
// dp_controller_if: instruction handshake and datapath control bundle of dp_controller
interface dp_controller_if;
   import dp_ctrl_pkg::*;
   logic [31:0]      instr;
   logic             instr_valid;
   logic [3:0]       status_in;
   logic             waiting;
   logic             done;
   logic             undef;
   logic [RF_AW-1:0] rf_addr_a;
   logic [RF_AW-1:0] rf_addr_b;
   logic [RF_AW-1:0] rf_w_addr;
   logic             rf_w_en;
   logic             en_A;
   logic             en_B;
   logic             en_S;
   logic             en_C;
   logic             en_status;
   logic             sel_A_zero;
   logic             sel_B_imm;
   logic [OP_W-1:0]  alu_op;
   logic [1:0]       shift_op;
   logic             shift_src;
   logic [4:0]       shift_imm;
   logic [11:0]      imm12;
   modport master (
      output instr, instr_valid, status_in,
      input  waiting, done, undef, rf_addr_a, rf_addr_b, rf_w_addr, rf_w_en,
             en_A, en_B, en_S, en_C, en_status, sel_A_zero, sel_B_imm,
             alu_op, shift_op, shift_src, shift_imm, imm12
   );
   modport slave (
      input  instr, instr_valid, status_in,
      output waiting, done, undef, rf_addr_a, rf_addr_b, rf_w_addr, rf_w_en,
             en_A, en_B, en_S, en_C, en_status, sel_A_zero, sel_B_imm,
             alu_op, shift_op, shift_src, shift_imm, imm12
   );
endinterface

// File: rtl/dp_cond_eval.sv
// dp_cond_eval: ARM condition field against NZCV flags, pass=1 when the instruction may execute
module dp_cond_eval
   import dp_ctrl_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_pass
);
   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = i_nzcv;
   // decode each condition code; NV never passes
   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         CC_EQ: o_pass = w_z;
         CC_NE: o_pass = !w_z;
         CC_CS: o_pass = w_c;
         CC_CC: o_pass = !w_c;
         CC_MI: o_pass = w_n;
         CC_PL: o_pass = !w_n;
         CC_VS: o_pass = w_v;
         CC_VC: o_pass = !w_v;
         CC_HI: o_pass = w_c && !w_z;
         CC_LS: o_pass = !w_c || w_z;
         CC_GE: o_pass = w_n == w_v;
         CC_LT: o_pass = w_n != w_v;
         CC_GT: o_pass = !w_z && (w_n == w_v);
         CC_LE: o_pass = w_z || (w_n != w_v);
         CC_AL: o_pass = 1'b1;
         default: o_pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/dp_controller.sv
// dp_controller: multi-cycle sequencer for the data-processing datapath
// Optional conditional execution via DP_COND_EXEC_EN; without it every defined instruction runs as AL.
module dp_controller
   import dp_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   dp_controller_if.slave   bus
);
   logic [2:0]  r_state;
   logic [31:0] r_ir;
   logic        r_skip;
   logic        r_undef;
   logic        w_pass;
   logic        w_undef_in;
   logic        w_reg_shift;
   logic        w_cmp;
   logic        w_wr;
   logic        w_wait, w_ab, w_s, w_ex, w_wb;
   logic        w_unused;
`ifdef DP_COND_EXEC_EN
   dp_cond_eval u_cond (
      .i_cond (bus.instr[31:28]),
      .i_nzcv (bus.status_in),
      .o_pass (w_pass)
   );
`else
   assign w_pass = 1'b1;
`endif
   assign w_unused    = ^{r_ir[31:26], bus.status_in};
   assign w_undef_in  = bus.instr[27:26] != 2'b00;
   assign w_reg_shift = !r_ir[25] && r_ir[4];
   assign w_cmp       = r_ir[24:23] == 2'b10;
   assign w_wait      = r_state == ST_WAIT;
   assign w_ab        = r_state == ST_LOAD_AB;
   assign w_s         = r_state == ST_LOAD_S;
   assign w_ex        = r_state == ST_EXEC;
   assign w_wb        = r_state == ST_WB;
   assign w_wr        = w_wb && !r_skip && !w_cmp;
   // sequence state; instruction captured only while idle, undefined ones dropped with a pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_WAIT;
         r_ir    <= '0;
         r_skip  <= 1'b0;
         r_undef <= 1'b0;
      end else begin
         r_undef <= 1'b0;
         case (r_state)
            ST_WAIT: if (bus.instr_valid) begin
               r_ir    <= bus.instr;
               r_undef <= w_undef_in;
               r_skip  <= !w_pass;
               r_state <= w_undef_in ? ST_WAIT : w_pass ? ST_LOAD_AB : ST_WB;
            end
            ST_LOAD_AB: r_state <= w_reg_shift ? ST_LOAD_S : ST_EXEC;
            ST_LOAD_S:  r_state <= ST_EXEC;
            ST_EXEC:    r_state <= ST_WB;
            default:    r_state <= ST_WAIT;
         endcase
      end
   end
   assign bus.waiting    = w_wait;
   assign bus.done       = w_wb;
   assign bus.undef      = r_undef;
   assign bus.rf_addr_a  = w_ab ? r_ir[19:16] : w_s ? r_ir[11:8] : '0;
   assign bus.rf_addr_b  = w_ab ? r_ir[3:0] : '0;
   assign bus.rf_w_en    = w_wr;
   assign bus.rf_w_addr  = w_wr ? r_ir[15:12] : '0;
   assign bus.en_A       = w_ab;
   assign bus.en_B       = w_ab;
   assign bus.en_S       = w_s;
   assign bus.en_C       = w_ex;
   assign bus.en_status  = w_ex && (r_ir[20] || w_cmp);
   assign bus.sel_A_zero = w_ex && (r_ir[24:21] == OP_MOV || r_ir[24:21] == OP_MVN);
   assign bus.sel_B_imm  = w_ex && r_ir[25];
   assign bus.alu_op     = w_ex ? r_ir[24:21] : '0;
   assign bus.shift_op   = w_ex ? r_ir[6:5] : '0;
   assign bus.shift_src  = (w_s || w_ex) && w_reg_shift;
   assign bus.shift_imm  = w_ex ? r_ir[11:7] : '0;
   assign bus.imm12      = w_ex ? r_ir[11:0] : '0;
endmodule

// File: tb/tb_dp_controller.sv
// tb_dp_controller: directed table plus random instructions checked cycle by cycle against a trace model
module tb_dp_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   dp_controller_if bus ();
   dp_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {
      logic        waiting, done, undef;
      logic [3:0]  rf_addr_a, rf_addr_b, rf_w_addr;
      logic        rf_w_en, en_A, en_B, en_S, en_C, en_status, sel_A_zero, sel_B_imm;
      logic [3:0]  alu_op;
      logic [1:0]  shift_op;
      logic        shift_src;
      logic [4:0]  shift_imm;
      logic [11:0] imm12;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  nzcv;
      int          busy;
      bit          wen, st, und;
      string       name;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   out_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   function automatic out_t sample();
      out_t o;
      o.waiting = bus.waiting; o.done = bus.done; o.undef = bus.undef;
      o.rf_addr_a = bus.rf_addr_a; o.rf_addr_b = bus.rf_addr_b; o.rf_w_addr = bus.rf_w_addr;
      o.rf_w_en = bus.rf_w_en; o.en_A = bus.en_A; o.en_B = bus.en_B; o.en_S = bus.en_S;
      o.en_C = bus.en_C; o.en_status = bus.en_status; o.sel_A_zero = bus.sel_A_zero;
      o.sel_B_imm = bus.sel_B_imm; o.alu_op = bus.alu_op; o.shift_op = bus.shift_op;
      o.shift_src = bus.shift_src; o.shift_imm = bus.shift_imm; o.imm12 = bus.imm12;
      return o;
   endfunction

   function automatic out_t idle();
      out_t o = '0;
      o.waiting = 1'b1;
      return o;
   endfunction

   // ARM rule: pairs of codes share a base test, odd code inverts it; AL always, NV never
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n = f[3], z = f[2], cy = f[1], v = f[0], b;
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cy;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cy && !z;
         3'd5: b = n == v;
         3'd6: b = !z && (n == v);
         default: b = 1'b1;
      endcase
`ifdef DP_COND_EXEC_EN
      return c == 4'hF ? 1'b0 : c[3:1] == 3'd7 ? 1'b1 : bit'(b ^ c[0]);
`else
      return 1'b1;
`endif
   endfunction

   // expected per-cycle outputs from acceptance until the controller is idle again
   task automatic build(input logic [31:0] ins, input logic [3:0] f);
      out_t o;
      logic [3:0] op = ins[24:21];
      bit regsh = !ins[25] && ins[4];
      bit cmp = op[3:2] == 2'b10;
      exp_q.delete();
      if (ins[27:26] != 2'b00) begin
         o = idle(); o.undef = 1'b1; exp_q.push_back(o);
         return;
      end
      if (!cond_ok(ins[31:28], f)) begin
         o = '0; o.done = 1'b1; exp_q.push_back(o);
         return;
      end
      o = '0; o.rf_addr_a = ins[19:16]; o.rf_addr_b = ins[3:0]; o.en_A = 1'b1; o.en_B = 1'b1;
      exp_q.push_back(o);
      if (regsh) begin
         o = '0; o.rf_addr_a = ins[11:8]; o.en_S = 1'b1; o.shift_src = 1'b1;
         exp_q.push_back(o);
      end
      o = '0; o.en_C = 1'b1; o.alu_op = op; o.shift_op = ins[6:5]; o.shift_src = regsh;
      o.shift_imm = ins[11:7]; o.imm12 = ins[11:0]; o.sel_B_imm = ins[25];
      o.sel_A_zero = op == 4'b1101 || op == 4'b1111; o.en_status = ins[20] || cmp;
      exp_q.push_back(o);
      o = '0; o.done = 1'b1; o.rf_w_en = !cmp; o.rf_w_addr = cmp ? 4'd0 : ins[15:12];
      exp_q.push_back(o);
   endtask

   // issue one instruction, flood the bus with junk while busy, compare every cycle
   task automatic run(input logic [31:0] ins, input logic [3:0] f,
                      output int busy, output bit wen, output bit st, output bit und);
      out_t o;
      int k = 0;
      busy = 0; wen = 0; st = 0; und = 0;
      while (!bus.waiting && k < 10) begin @(negedge clk); k++; end
      chk("ready", 64'(bus.waiting), 64'd1);
      build(ins, f);
      bus.instr = ins; bus.status_in = f; bus.instr_valid = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         o = sample();
         chk($sformatf("cycle%0d_%08h", i, ins), 64'(o), 64'(exp_q[i]));
         busy += int'(!o.waiting); wen |= o.rf_w_en; st |= o.en_status; und |= o.undef;
         if (i == exp_q.size() - 1) bus.instr_valid = 1'b0;
         else begin bus.instr = $urandom; bus.status_in = 4'($urandom); bus.instr_valid = 1'b1; end
      end
      @(negedge clk);
      chk($sformatf("idle_%08h", ins), 64'(sample()), 64'(idle()));
   endtask

   vec_t v[$];
   int   busy;
   bit   wen, st, und;
   logic [31:0] ins;

   initial begin
      bus.instr = '0; bus.instr_valid = 1'b0; bus.status_in = '0;
      v.push_back('{32'hE3A03005, 4'h0, 3, 1'b1, 1'b0, 1'b0, "mov_imm"});
      v.push_back('{32'hE0822210, 4'h0, 4, 1'b1, 1'b0, 1'b0, "add_regshift"});
      v.push_back('{32'hE1500001, 4'h0, 3, 1'b0, 1'b1, 1'b0, "cmp"});
`ifdef DP_COND_EXEC_EN
      v.push_back('{32'h00800000, 4'h0, 1, 1'b0, 1'b0, 1'b0, "addeq_fail"});
      v.push_back('{32'hF0800000, 4'hF, 1, 1'b0, 1'b0, 1'b0, "nv_fail"});
`else
      v.push_back('{32'h00800000, 4'h0, 3, 1'b1, 1'b0, 1'b0, "addeq_as_al"});
      v.push_back('{32'hF0800000, 4'hF, 3, 1'b1, 1'b0, 1'b0, "nv_as_al"});
`endif
      v.push_back('{32'h00800000, 4'h4, 3, 1'b1, 1'b0, 1'b0, "addeq_pass"});
      v.push_back('{32'hE7000000, 4'h0, 0, 1'b0, 1'b0, 1'b1, "undef"});
      v.push_back('{32'hE1B0F00E, 4'h0, 3, 1'b1, 1'b1, 1'b0, "movs_pc"});
      #2;
      chk("reset_outputs", 64'(sample()), 64'(idle()));
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("after_release", 64'(sample()), 64'(idle()));
      foreach (v[i]) begin
         run(v[i].instr, v[i].nzcv, busy, wen, st, und);
         chk({v[i].name, "_latency"}, 64'(busy), 64'(v[i].busy));
         chk({v[i].name, "_wen"}, 64'(wen), 64'(v[i].wen));
         chk({v[i].name, "_status"}, 64'(st), 64'(v[i].st));
         chk({v[i].name, "_undef"}, 64'(und), 64'(v[i].und));
      end
      // reset while ADD R1,R1,#8 is in EXEC: abandon it, no writeback afterwards
      bus.instr = 32'hE2811008; bus.instr_valid = 1'b1;
      @(negedge clk);
      chk("rst_seq_ab", 64'(bus.en_A), 64'd1);
      @(negedge clk);
      chk("rst_seq_exec", 64'(bus.en_C), 64'd1);
      #1 rst_n = 1'b0;
      #1 chk("rst_async", 64'(sample()), 64'(idle()));
      bus.instr_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d", i), 64'(sample()), 64'(idle()));
      end
      for (int i = 0; i < 300; i++) begin
         ins = $urandom;
         if ($urandom_range(7) != 0) ins[27:26] = 2'b00;
         run(ins, 4'($urandom), busy, wen, st, und);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
